fetch_pc_unit: RTL and testbench

Parametrised fetch-stage program-counter unit for the pipelined MIPS core. Holds the fetch PC register and computes the next PC each cycle from sequential, jump, predicted-branch and execute-stage redirect sources. Sits at the head of the F stage: drives the instruction-memory address and passes `f_valP` and the branch prediction down the pipe. Supersedes the purely combinational `next_pc`.

---
 rtl/fetch_pc_unit_pkg.sv | 64 ++++++
 rtl/fetch_pc_unit_bht.sv | 56 +++++
 rtl/fetch_pc_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_pc_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_unit_pkg
// Purpose  : Shared defines for the pipelined MIPS core front end.
//            - primary opcode constants (instr[31:26])
//            - 2-bit branch-history counter encodings and their update rule
//            - small opcode-class helpers used by the fetch stage
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pc_unit_pkg;

  // --------------------------------------------------------------------------
  // Primary opcodes
  // --------------------------------------------------------------------------
  localparam logic [5:0] IROP  = 6'h00;  // R-type (JR lives here too)
  localparam logic [5:0] IJ    = 6'h02;
  localparam logic [5:0] IJAL  = 6'h03;
  localparam logic [5:0] IBEQ  = 6'h04;
  localparam logic [5:0] IBNE  = 6'h05;
  localparam logic [5:0] IADDI = 6'h08;
  localparam logic [5:0] IORI  = 6'h0D;
  localparam logic [5:0] ILUI  = 6'h0F;
  localparam logic [5:0] ILW   = 6'h23;
  localparam logic [5:0] ISW   = 6'h2B;

  // --------------------------------------------------------------------------
  // Branch-history counter encodings (2-bit saturating, MSB = predict taken)
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    BHT_SNT = 2'b00,  // strongly not-taken
    BHT_WNT = 2'b01,  // weakly not-taken
    BHT_WT  = 2'b10,  // weakly taken
    BHT_ST  = 2'b11   // strongly taken
  } bht_cnt_e;

  localparam bht_cnt_e BHT_RESET = BHT_WNT;

  // Saturating step of one counter toward the resolved direction.
  function automatic bht_cnt_e bht_next(input bht_cnt_e cur, input logic taken);
    bht_cnt_e nxt;
    nxt = cur;
    unique case (cur)
      BHT_SNT: nxt = taken ? BHT_WNT : BHT_SNT;
      BHT_WNT: nxt = taken ? BHT_WT  : BHT_SNT;
      BHT_WT:  nxt = taken ? BHT_ST  : BHT_WNT;
      BHT_ST:  nxt = taken ? BHT_ST  : BHT_WT;
      default: nxt = BHT_RESET;
    endcase
    return nxt;
  endfunction

  // Unconditional PC-region jumps (target formed from the 26-bit index).
  function automatic logic op_is_jump(input logic [5:0] op);
    return (op == IJ) || (op == IJAL);
  endfunction

  // Conditional branches that consult the predictor.
  function automatic logic op_is_cond_branch(input logic [5:0] op);
    return (op == IBEQ) || (op == IBNE);
  endfunction

endpackage : fetch_pc_unit_pkg
`default_nettype wire

// File: rtl/fetch_pc_unit_bht.sv
`default_nettype none
// ============================================================================
// Module   : branch_hist_table
// Purpose  : Table of DEPTH 2-bit saturating counters for dynamic branch
//            prediction. One combinational lookup port, one synchronous
//            update port. A lookup and an update of the same index in the
//            same cycle sees the counter value from before the update.
// Ports    : clk             - clock, updates on rising edge
//            rst_n           - asynchronous active-low reset (counters -> 01)
//            lookup_idx_i    - index of the instruction being fetched
//            lookup_taken_o  - prediction (counter MSB) at lookup_idx_i
//            upd_en_i        - a branch resolved this cycle
//            upd_idx_i       - index of the resolved branch
//            upd_taken_i     - actual direction of the resolved branch
// Revision : 1.0 - initial release
// ============================================================================
module branch_hist_table
  import fetch_pc_unit_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] lookup_idx_i,
  output logic             lookup_taken_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  bht_cnt_e cnt_q [DEPTH];
  bht_cnt_e cnt_d [DEPTH];

  // Read straight from the registers so a same-cycle update is not visible.
  assign lookup_taken_o = cnt_q[lookup_idx_i][1];

  always_comb begin
    cnt_d = cnt_q;
    if (upd_en_i) begin
      cnt_d[upd_idx_i] = bht_next(cnt_q[upd_idx_i], upd_taken_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= BHT_RESET;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : branch_hist_table
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_unit
// Purpose  : Fetch-stage program counter. Holds the fetch PC and selects the
//            next PC each cycle, highest priority first:
//              execute redirect > stall > J/JAL > predicted-taken branch
//              > sequential (F_pc + 4).
//            All address arithmetic wraps modulo 2^XLEN.
// Config   : `PC_BHT_EN defined   - dynamic prediction from a table of
//                                    BHT_DEPTH 2-bit counters (sub-module
//                                    branch_hist_table), trained by the
//                                    execute-stage resolve port.
//            `PC_BHT_EN undefined - static backward-taken / forward-not-taken
//                                    from the offset sign; resolve port unused.
// Ports    : clk            - clock
//            rst_n          - asynchronous active-low reset (F_pc = RESET_PC)
//            stall          - hold F_pc
//            f_op           - opcode of the instruction at F_pc
//            f_valC         - immediate (J index or sign-extended offset)
//            e_resolve      - execute resolved a conditional branch
//            e_taken        - actual direction of that branch
//            e_pc           - PC of that branch
//            e_mispredict   - redirect fetch (overrides stall)
//            e_redirect_pc  - redirect target
//            F_pc           - current fetch PC
//            f_valP         - F_pc + 4
//            f_pred_taken   - prediction for the instruction at F_pc
// Revision : 1.0 - initial release, replaces combinational next_pc
// ============================================================================
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     BHT_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic [5:0]      f_op,
  input  logic [XLEN-1:0] f_valC,
  input  logic            e_resolve,
  input  logic            e_taken,
  input  logic [XLEN-1:0] e_pc,
  input  logic            e_mispredict,
  input  logic [XLEN-1:0] e_redirect_pc,
  output logic [XLEN-1:0] F_pc,
  output logic [XLEN-1:0] f_valP,
  output logic            f_pred_taken
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] valp;
  logic [XLEN-1:0] jump_tgt;
  logic [XLEN-1:0] branch_tgt;
  logic            is_jump;
  logic            is_branch;
  logic            pred_raw;

  // --------------------------------------------------------------------------
  // Candidate targets
  // --------------------------------------------------------------------------
  assign valp       = pc_q + PC_STEP;
  assign branch_tgt = valp + (f_valC << 2);
  assign is_jump    = op_is_jump(f_op);
  assign is_branch  = op_is_cond_branch(f_op);

  // J/JAL keep the top PC bits of the delay-slot address; at XLEN = 28 there
  // are no such bits and the target is just the shifted index.
  generate
    if (XLEN > 28) begin : g_jump_region
      assign jump_tgt = {valp[XLEN-1:28], f_valC[25:0], 2'b00};
    end else begin : g_jump_flat
      assign jump_tgt = {f_valC[25:0], 2'b00};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Direction predictor
  // --------------------------------------------------------------------------
`ifdef PC_BHT_EN
  localparam int unsigned BHT_IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

  branch_hist_table #(
    .DEPTH (BHT_DEPTH)
  ) u_bht (
    .clk            (clk),
    .rst_n          (rst_n),
    .lookup_idx_i   (pc_q[BHT_IDX_W+1:2]),
    .lookup_taken_o (pred_raw),
    .upd_en_i       (e_resolve),
    .upd_idx_i      (e_pc[BHT_IDX_W+1:2]),
    .upd_taken_i    (e_taken)
  );

  // Only the index bits of the resolved PC address the table.
  logic unused_epc_bits;
  assign unused_epc_bits = ^{e_pc[XLEN-1:BHT_IDX_W+2], e_pc[1:0]};
`else
  // Backward (negative offset) branches are usually loop back-edges.
  assign pred_raw = f_valC[XLEN-1];

  logic unused_resolve_port;
  assign unused_resolve_port = ^{e_resolve, e_taken, e_pc};
  localparam int unsigned unused_bht_depth = BHT_DEPTH;
`endif

  assign f_pred_taken = is_branch & pred_raw;

  // --------------------------------------------------------------------------
  // Next-PC selection
  // --------------------------------------------------------------------------
  always_comb begin
    pc_d = valp;
    if (e_mispredict) begin
      pc_d = e_redirect_pc;  // taken verbatim, low bits included
    end else if (stall) begin
      pc_d = pc_q;
    end else if (is_jump) begin
      pc_d = jump_tgt;
    end else if (f_pred_taken) begin
      pc_d = branch_tgt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign F_pc   = pc_q;
  assign f_valP = valp;

endmodule : fetch_pc_unit
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_unit
// Purpose  : Self-checking bench for fetch_pc_unit (RESET_PC = 0, XLEN = 32,
//            BHT_DEPTH = 16). A reference next-PC model pushes the expected
//            next F_pc and the expected prediction when each stimulus row is
//            driven; they are popped and compared when the DUT produces them.
//            Works for both the static build and the `PC_BHT_EN build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;
  import fetch_pc_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [5:0]  f_op;
  logic [31:0] f_valC;
  logic        e_resolve;
  logic        e_taken;
  logic [31:0] e_pc;
  logic        e_mispredict;
  logic [31:0] e_redirect_pc;
  logic [31:0] F_pc;
  logic [31:0] f_valP;
  logic        f_pred_taken;

  fetch_pc_unit #(
    .XLEN      (32),
    .RESET_PC  (32'h0),
    .BHT_DEPTH (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .f_op          (f_op),
    .f_valC        (f_valC),
    .e_resolve     (e_resolve),
    .e_taken       (e_taken),
    .e_pc          (e_pc),
    .e_mispredict  (e_mispredict),
    .e_redirect_pc (e_redirect_pc),
    .F_pc          (F_pc),
    .f_valP        (f_valP),
    .f_pred_taken  (f_pred_taken)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] valc;
    logic        stl;
    logic        mis;
    logic [31:0] rdr;
    logic        res;
    logic        tk;
    logic [31:0] epc;
  } stim_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] mpc;
  logic [1:0]  mcnt [16];
  logic [31:0] exp_valp;
  logic [31:0] exp_pc_q [$];
  logic        exp_pred_q [$];

  task automatic model_reset();
    mpc = 32'h0;
    for (int i = 0; i < 16; i++) mcnt[i] = 2'b01;
    exp_pc_q.delete();
    exp_pred_q.delete();
  endtask

  // Drive one row and push what the DUT must show for it.
  task automatic apply(input stim_t s);
    logic [31:0] valp;
    logic [31:0] nxt;
    logic        br;
    logic        pred;
    logic [3:0]  idx;
    f_op          = s.op;
    f_valC        = s.valc;
    stall         = s.stl;
    e_mispredict  = s.mis;
    e_redirect_pc = s.rdr;
    e_resolve     = s.res;
    e_taken       = s.tk;
    e_pc          = s.epc;
    valp     = mpc + 32'd4;
    exp_valp = valp;
    br       = (s.op == IBEQ) || (s.op == IBNE);
`ifdef PC_BHT_EN
    pred = br && mcnt[mpc[5:2]][1];
`else
    pred = br && s.valc[31];
`endif
    if (s.mis)                            nxt = s.rdr;
    else if (s.stl)                       nxt = mpc;
    else if (s.op == IJ || s.op == IJAL)  nxt = {valp[31:28], s.valc[25:0], 2'b00};
    else if (pred)                        nxt = valp + (s.valc << 2);
    else                                  nxt = valp;
`ifdef PC_BHT_EN
    if (s.res) begin
      idx = s.epc[5:2];
      if (s.tk && mcnt[idx] != 2'b11)       mcnt[idx] = mcnt[idx] + 2'b01;
      else if (!s.tk && mcnt[idx] != 2'b00) mcnt[idx] = mcnt[idx] - 2'b01;
    end
`else
    idx = 4'h0;
`endif
    exp_pred_q.push_back(pred);
    exp_pc_q.push_back(nxt);
    mpc = nxt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; f_op = IROP; f_valC = '0;
    e_resolve = 1'b0; e_taken = 1'b0; e_pc = '0;
    e_mispredict = 1'b0; e_redirect_pc = '0;
    #3;
    total++; if (F_pc !== 32'h0)   begin bad++; $display("FAIL reset_pc: got %h want %h", F_pc, 32'h0); end
    total++; if (f_valP !== 32'h4) begin bad++; $display("FAIL reset_valp: got %h want %h", f_valP, 32'h4); end
    total++; if (f_pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred: got %b want 0", f_pred_taken); end
    @(negedge clk); rst_n = 1'b1; model_reset();
    #1;
    total++; if (F_pc !== 32'h0) begin bad++; $display("FAIL release_pc: got %h want %h", F_pc, 32'h0); end
  endtask

  task automatic test_sequential();
    stim_t tbl [3] = '{
      '{IROP,  32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0},
      '{IROP,  32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0},
      '{IADDI, 32'h7, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0}
    };
    logic [31:0] e; logic p;
    foreach (tbl[i]) begin
      apply(tbl[i]); #1;
      p = exp_pred_q.pop_front();
      total++; if (f_pred_taken !== p) begin bad++; $display("FAIL seq_pred[%0d]: got %b want %b", i, f_pred_taken, p); end
      total++; if (f_valP !== exp_valp) begin bad++; $display("FAIL seq_valp[%0d]: got %h want %h", i, f_valP, exp_valp); end
      @(posedge clk); #1;
      e = exp_pc_q.pop_front();
      total++; if (F_pc !== e) begin bad++; $display("FAIL seq_pc[%0d]: got %h want %h", i, F_pc, e); end
    end
  endtask

  task automatic test_jump();
    stim_t tbl [4] = '{
      '{IROP, 32'h0,        1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 32'h0},
      '{IJ,   32'd22,       1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0},
      '{IROP, 32'h0,        1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0},
      '{IJAL, 32'h03FFFFFF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0}
    };
    logic [31:0] e; logic p;
    foreach (tbl[i]) begin
      apply(tbl[i]); #1;
      p = exp_pred_q.pop_front();
      total++; if (f_pred_taken !== p) begin bad++; $display("FAIL jump_pred[%0d]: got %b want %b", i, f_pred_taken, p); end
      @(posedge clk); #1;
      e = exp_pc_q.pop_front();
      total++; if (F_pc !== e) begin bad++; $display("FAIL jump_pc[%0d]: got %h want %h", i, F_pc, e); end
    end
  endtask

  task automatic test_stall_redirect();
    stim_t tbl [6] = '{
      '{IROP, 32'h0,        1'b0, 1'b1, 32'h5C,  1'b0, 1'b0, 32'h0},
      '{IROP, 32'h0,        1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0},
      '{IJ,   32'd22,       1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0},
      '{IBEQ, 32'hFFFFFFF0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0},
      '{IJ,   32'd22,       1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0},
      '{IROP, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0}
    };
    logic [31:0] e; logic p;
    foreach (tbl[i]) begin
      apply(tbl[i]); #1;
      p = exp_pred_q.pop_front();
      total++; if (f_pred_taken !== p) begin bad++; $display("FAIL stall_pred[%0d]: got %b want %b", i, f_pred_taken, p); end
      @(posedge clk); #1;
      e = exp_pc_q.pop_front();
      total++; if (F_pc !== e) begin bad++; $display("FAIL stall_pc[%0d]: got %h want %h", i, F_pc, e); end
    end
  endtask

  task automatic test_static_pred();
    stim_t tbl [7] = '{
      '{IROP, 32'h0,        1'b0, 1'b1, 32'h60, 1'b0, 1'b0, 32'h0},
      '{IBEQ, 32'hFFFFFFFE, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0},
      '{IROP, 32'h0,        1'b0, 1'b1, 32'h60, 1'b0, 1'b0, 32'h0},
      '{IBEQ, 32'h4,        1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0},
      '{IBNE, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0},
      '{IROP, 32'hFFFFFFFE, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0},
      '{ISW,  32'hFFFFFFFC, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0}
    };
    logic [31:0] e; logic p;
    foreach (tbl[i]) begin
      apply(tbl[i]); #1;
      p = exp_pred_q.pop_front();
      total++; if (f_pred_taken !== p) begin bad++; $display("FAIL pred_dir[%0d]: got %b want %b", i, f_pred_taken, p); end
      @(posedge clk); #1;
      e = exp_pc_q.pop_front();
      total++; if (F_pc !== e) begin bad++; $display("FAIL pred_pc[%0d]: got %h want %h", i, F_pc, e); end
    end
  endtask

  // Train index 0 (PC 0x40) with the fetch stalled on the same branch.
  task automatic test_branch_history();
    stim_t tbl [9] = '{
      '{IROP, 32'h0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0},
      '{IBEQ, 32'h8, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h40},
      '{IBEQ, 32'h8, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h40},
      '{IBEQ, 32'h8, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h40},
      '{IBEQ, 32'h8, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h44},
      '{IBEQ, 32'h8, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h40},
      '{IBEQ, 32'h8, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h40},
      '{IBEQ, 32'h8, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0},
      '{IBEQ, 32'h8, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0}
    };
    logic [31:0] e; logic p;
    foreach (tbl[i]) begin
      apply(tbl[i]); #1;
      p = exp_pred_q.pop_front();
      total++; if (f_pred_taken !== p) begin bad++; $display("FAIL bht_pred[%0d]: got %b want %b", i, f_pred_taken, p); end
      @(posedge clk); #1;
      e = exp_pc_q.pop_front();
      total++; if (F_pc !== e) begin bad++; $display("FAIL bht_pc[%0d]: got %h want %h", i, F_pc, e); end
    end
  endtask

  task automatic test_wrap();
    stim_t tbl [6] = '{
      '{IROP, 32'h0,        1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0},
      '{IROP, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0},
      '{IROP, 32'h0,        1'b0, 1'b1, 32'hF0000010, 1'b0, 1'b0, 32'h0},
      '{IJ,   32'h03FFFFFF, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0},
      '{IROP, 32'h0,        1'b0, 1'b1, 32'h00000103, 1'b0, 1'b0, 32'h0},
      '{IROP, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0}
    };
    logic [31:0] e;
    foreach (tbl[i]) begin
      apply(tbl[i]); #1;
      void'(exp_pred_q.pop_front());
      total++; if (f_valP !== exp_valp) begin bad++; $display("FAIL wrap_valp[%0d]: got %h want %h", i, f_valP, exp_valp); end
      @(posedge clk); #1;
      e = exp_pc_q.pop_front();
      total++; if (F_pc !== e) begin bad++; $display("FAIL wrap_pc[%0d]: got %h want %h", i, F_pc, e); end
    end
  endtask

  task automatic test_async_reset();
    stim_t pre [1] = '{
      '{IROP, 32'h0, 1'b0, 1'b1, 32'h88, 1'b0, 1'b0, 32'h0}
    };
    stim_t post [4] = '{
      '{IROP, 32'h0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0},
      '{IBEQ, 32'h8, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h40},
      '{IBEQ, 32'h8, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0},
      '{IROP, 32'h0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0}
    };
    logic [31:0] e; logic p;
    foreach (pre[i]) begin
      apply(pre[i]);
      @(posedge clk); #1;
      void'(exp_pred_q.pop_front());
      e = exp_pc_q.pop_front();
      total++; if (F_pc !== e) begin bad++; $display("FAIL arst_pre_pc: got %h want %h", F_pc, e); end
    end
    // Pending redirect and stall when reset hits between edges.
    e_mispredict = 1'b1; e_redirect_pc = 32'h200; stall = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++; if (F_pc !== 32'h0) begin bad++; $display("FAIL arst_immediate: got %h want %h", F_pc, 32'h0); end
    total++; if (f_valP !== 32'h4) begin bad++; $display("FAIL arst_valp: got %h want %h", f_valP, 32'h4); end
    @(posedge clk); #1;
    total++; if (F_pc !== 32'h0) begin bad++; $display("FAIL arst_held: got %h want %h", F_pc, 32'h0); end
    e_mispredict = 1'b0; stall = 1'b0; f_op = IROP;
    @(negedge clk); rst_n = 1'b1; model_reset();
    foreach (post[i]) begin
      apply(post[i]); #1;
      p = exp_pred_q.pop_front();
      total++; if (f_pred_taken !== p) begin bad++; $display("FAIL arst_pred[%0d]: got %b want %b", i, f_pred_taken, p); end
      @(posedge clk); #1;
      e = exp_pc_q.pop_front();
      total++; if (F_pc !== e) begin bad++; $display("FAIL arst_pc[%0d]: got %h want %h", i, F_pc, e); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_stall_redirect();
    test_static_pred();
    test_branch_history();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_fetch_pc_unit
`default_nettype wire
